// File: rtl/face_detection_host_master.sv
// Avalon-MM master that runs the face-detection command/status protocol from fabric.
// It takes a pixel stream, writes the reset / pixel / result command sequence, polls
// the slave status register, and returns result words on a valid-only stream.
module face_detection_host_master #(
    parameter int unsigned DATA_WIDTH  = 13,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned PIXEL_COUNT = 400,
    parameter int unsigned POLL_LIMIT  = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [11:0]           pix_data,
    output logic                  pix_ready,
    output logic                  res_valid,
    output logic [11:0]           res_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata
);

    localparam int unsigned PixW  = $clog2(PIXEL_COUNT + 1);
    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

    // Command codes written to the slave
    localparam logic [11:0] CmdReset    = 12'd5;
    localparam logic [11:0] CmdStartPix = 12'd1;
    localparam logic [11:0] CmdStopPix  = 12'd2;
    localparam logic [11:0] CmdStartRes = 12'd3;
    localparam logic [11:0] CmdStopRes  = 12'd4;

    // Status codes read back from the slave
    localparam logic [DATA_WIDTH-1:0] StsRdyPix    = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] StsEndPix    = DATA_WIDTH'(12);
    localparam logic [DATA_WIDTH-1:0] StsStartSend = DATA_WIDTH'(13);
    localparam logic [DATA_WIDTH-1:0] StsStopSend  = DATA_WIDTH'(14);
    localparam logic [DATA_WIDTH-1:0] StsFinish    = DATA_WIDTH'(15);

    typedef enum logic [3:0] {
        StIdle, StWrRst, StPollRdy, StWaitPix, StWrSp, StWrPx, StWrEp,
        StPollEnd, StWrSr, StPollSs, StRdRes, StWrStr, StPollSts, StDone
    } state_e;

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;   // a read was issued last cycle
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [11:0]       pix_q, pix_d;
    logic              terr_q, terr_d;

    logic              is_poll;
    logic              sts_match;
    state_e            match_st;
    logic [11:0]       wval;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_pend_q  <= 1'b0;
            pix_cnt_q  <= '0;
            poll_cnt_q <= '0;
            pix_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            pix_cnt_q  <= pix_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            pix_q      <= pix_d;
            terr_q     <= terr_d;
        end
    end

    // Next-state logic and bus/stream outputs
    always_comb begin
        state_d    = state_q;
        rd_pend_d  = 1'b0;
        pix_cnt_d  = pix_cnt_q;
        poll_cnt_d = poll_cnt_q;
        pix_d      = pix_q;
        terr_d     = terr_q;
        is_poll    = 1'b0;
        sts_match  = 1'b0;
        match_st   = StIdle;
        wval       = 12'd0;
        m_read     = 1'b0;
        m_write    = 1'b0;
        pix_ready  = 1'b0;
        res_valid  = 1'b0;
        res_data   = 12'd0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    terr_d    = 1'b0;
                    pix_cnt_d = '0;
                    state_d   = StWrRst;
                end
            end
            StWrRst: begin
                m_write = 1'b1;
                wval    = CmdReset;
                state_d = StPollRdy;
            end
            StPollRdy: begin
                is_poll   = 1'b1;
                sts_match = (m_readdata == StsRdyPix);
                match_st  = StWaitPix;
            end
            StWaitPix: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    pix_d   = pix_data;
                    state_d = StWrSp;
                end
            end
            StWrSp: begin
                m_write = 1'b1;
                wval    = CmdStartPix;
                state_d = StWrPx;
            end
            StWrPx: begin
                m_write = 1'b1;
                wval    = pix_q;
                state_d = StWrEp;
            end
            StWrEp: begin
                m_write   = 1'b1;
                wval      = CmdStopPix;
                pix_cnt_d = pix_cnt_q + 1'b1;
                state_d   = (pix_cnt_q == PixW'(PIXEL_COUNT - 1)) ? StPollEnd : StPollRdy;
            end
            StPollEnd: begin
                is_poll   = 1'b1;
                sts_match = (m_readdata == StsEndPix) || (m_readdata == StsRdyPix);
                match_st  = StWrSr;
            end
            StWrSr: begin
                m_write = 1'b1;
                wval    = CmdStartRes;
                state_d = StPollSs;
            end
            StPollSs: begin
                is_poll   = 1'b1;
                sts_match = (m_readdata == StsStartSend);
                match_st  = StRdRes;
            end
            StRdRes: begin
                if (!rd_pend_q) begin
                    m_read    = 1'b1;
                    rd_pend_d = 1'b1;
                end else begin
                    res_valid = 1'b1;
                    res_data  = m_readdata[11:0];
                    state_d   = StWrStr;
                end
            end
            StWrStr: begin
                m_write = 1'b1;
                wval    = CmdStopRes;
                state_d = StPollSts;
            end
            StPollSts: begin
                is_poll   = 1'b1;
                sts_match = (m_readdata == StsStopSend);
                match_st  = StWrSr;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Shared poll engine: issue, then sample; FINISH always wins
        if (is_poll) begin
            if (!rd_pend_q) begin
                m_read    = 1'b1;
                rd_pend_d = 1'b1;
            end else if (m_readdata == StsFinish) begin
                state_d = StDone;
            end else if (sts_match) begin
                state_d = match_st;
            end else if (poll_cnt_q == PollW'(POLL_LIMIT - 1)) begin
                terr_d  = 1'b1;
                state_d = StIdle;
            end else begin
                poll_cnt_d = poll_cnt_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            poll_cnt_d = '0;
        end
    end

    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign timeout_err = terr_q;
    assign m_address   = '0;
    assign m_writedata = DATA_WIDTH'(wval);

endmodule
